// File: rtl/ram_arb_if.sv
// Signal bundle between ram_arb and its neighbours: IFU and LSU request/response
// channels plus the single-port RAM command/data channel.
interface ram_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  i_ifu_req_valid;
  logic                  o_ifu_req_ready;
  logic [ADDR_WIDTH-1:0] i_ifu_req_addr;
  logic                  o_ifu_rsp_valid;
  logic [DATA_WIDTH-1:0] o_ifu_rsp_data;

  logic                  i_lsu_req_valid;
  logic                  o_lsu_req_ready;
  logic                  i_lsu_req_wr;
  logic [ADDR_WIDTH-1:0] i_lsu_req_addr;
  logic [DATA_WIDTH-1:0] i_lsu_req_wdata;
  logic [MASK_WIDTH-1:0] i_lsu_req_mask;
  logic                  o_lsu_rsp_valid;
  logic [DATA_WIDTH-1:0] o_lsu_rsp_data;

  logic                  o_ram_rd_en;
  logic [ADDR_WIDTH-1:0] o_ram_rd_addr;
  logic [DATA_WIDTH-1:0] i_ram_rd_data;
  logic                  o_ram_wr_en;
  logic [ADDR_WIDTH-1:0] o_ram_wr_addr;
  logic [DATA_WIDTH-1:0] o_ram_wr_data;
  logic [MASK_WIDTH-1:0] o_ram_wr_mask;

  // slave: the arbiter itself; master: requesters and RAM around it
  modport slave (
    input  i_ifu_req_valid, i_ifu_req_addr,
    input  i_lsu_req_valid, i_lsu_req_wr, i_lsu_req_addr, i_lsu_req_wdata, i_lsu_req_mask,
    input  i_ram_rd_data,
    output o_ifu_req_ready, o_ifu_rsp_valid, o_ifu_rsp_data,
    output o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rsp_data,
    output o_ram_rd_en, o_ram_rd_addr,
    output o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_wr_mask
  );

  modport master (
    output i_ifu_req_valid, i_ifu_req_addr,
    output i_lsu_req_valid, i_lsu_req_wr, i_lsu_req_addr, i_lsu_req_wdata, i_lsu_req_mask,
    output i_ram_rd_data,
    input  o_ifu_req_ready, o_ifu_rsp_valid, o_ifu_rsp_data,
    input  o_lsu_req_ready, o_lsu_rsp_valid, o_lsu_rsp_data,
    input  o_ram_rd_en, o_ram_rd_addr,
    input  o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_wr_mask
  );
endinterface

// File: rtl/ram_arb.sv
// Shares one single-port data RAM between instruction fetch (read-only) and
// load/store (read or masked write); one transaction in flight, round-robin on ties.
module ram_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_RD_LAT = 1
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  ram_arb_if.slave   bus,
  output logic [1:0] o_dbg_state
);
  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state, state_next;
  logic                  r_last;
  logic                  r_owner;
  logic                  r_wr;
  logic [2:0]            r_cnt;
  logic                  ifu_grant, lsu_grant;
  logic                  accept, acc_wr, wait_done;
  logic [ADDR_WIDTH-1:0] acc_addr;

  // Handshake: a request transfers on a rising edge where valid && ready are both
  // high; ready is only ever raised for the arbitration winner while IDLE and out
  // of reset, and requesters keep valid and payload stable until they see ready.
  always_comb begin
    ifu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (state == S_IDLE && !i_sys_rst) begin
      if (bus.i_lsu_req_valid && (!bus.i_ifu_req_valid || r_last == REQ_IFU))
        lsu_grant = 1'b1;
      else if (bus.i_ifu_req_valid)
        ifu_grant = 1'b1;
    end
  end

  assign accept    = ifu_grant | lsu_grant;
  assign acc_wr    = lsu_grant & bus.i_lsu_req_wr;
  assign acc_addr  = lsu_grant ? bus.i_lsu_req_addr : bus.i_ifu_req_addr;
  assign wait_done = (state == S_WAIT) && (r_cnt == 3'd0);

  assign bus.o_ifu_req_ready = ifu_grant;
  assign bus.o_lsu_req_ready = lsu_grant;
  assign o_dbg_state         = state;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) state <= S_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_ISSUE;
      S_ISSUE: state_next = r_wr ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 3'd0) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_last  <= REQ_IFU;
      r_owner <= REQ_IFU;
      r_wr    <= 1'b0;
      r_cnt   <= 3'd0;
    end else begin
      if (accept) begin
        r_last  <= lsu_grant ? REQ_LSU : REQ_IFU;
        r_owner <= lsu_grant ? REQ_LSU : REQ_IFU;
        r_wr    <= acc_wr;
      end
      if (state == S_ISSUE && !r_wr)
        r_cnt <= 3'(RAM_RD_LAT - 1);
      else if (state == S_WAIT && r_cnt != 3'd0)
        r_cnt <= r_cnt - 3'd1;
    end
  end

  // Command registers load on accept so they are live exactly for the ISSUE cycle.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      bus.o_ram_rd_en     <= 1'b0;
      bus.o_ram_rd_addr   <= {ADDR_WIDTH{1'b0}};
      bus.o_ram_wr_en     <= 1'b0;
      bus.o_ram_wr_addr   <= {ADDR_WIDTH{1'b0}};
      bus.o_ram_wr_data   <= {DATA_WIDTH{1'b0}};
      bus.o_ram_wr_mask   <= {(DATA_WIDTH/8){1'b0}};
      bus.o_ifu_rsp_valid <= 1'b0;
      bus.o_ifu_rsp_data  <= {DATA_WIDTH{1'b0}};
      bus.o_lsu_rsp_valid <= 1'b0;
      bus.o_lsu_rsp_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      bus.o_ram_rd_en   <= accept && !acc_wr;
      bus.o_ram_rd_addr <= (accept && !acc_wr) ? acc_addr : {ADDR_WIDTH{1'b0}};
      bus.o_ram_wr_en   <= acc_wr;
      bus.o_ram_wr_addr <= acc_wr ? bus.i_lsu_req_addr : {ADDR_WIDTH{1'b0}};
      bus.o_ram_wr_data <= acc_wr ? bus.i_lsu_req_wdata : {DATA_WIDTH{1'b0}};
      bus.o_ram_wr_mask <= acc_wr ? bus.i_lsu_req_mask : {(DATA_WIDTH/8){1'b0}};

      bus.o_ifu_rsp_valid <= wait_done && (r_owner == REQ_IFU);
      bus.o_ifu_rsp_data  <= (wait_done && r_owner == REQ_IFU) ? bus.i_ram_rd_data
                                                               : {DATA_WIDTH{1'b0}};
      bus.o_lsu_rsp_valid <= (wait_done && r_owner == REQ_LSU) || (state == S_ISSUE && r_wr);
      bus.o_lsu_rsp_data  <= (wait_done && r_owner == REQ_LSU) ? bus.i_ram_rd_data
                                                               : {DATA_WIDTH{1'b0}};
    end
  end
endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: directed requests with hand-computed responses, checked by
// cycle-exact scoreboards on the response and RAM command channels.
module tb_ram_arb;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int MW    = DW / 8;
  localparam int LAT   = 1;
  localparam int LAT4  = 4;
  localparam int RSP_W = 1 + DW + 32;
  localparam int CMD_W = 1 + AW + DW + MW + 32;

  logic clk = 1'b0;
  logic rst;
  logic ram_load;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ifu_rsp_cnt = 0;
  int   lsu_rsp_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  ram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus4 ();
  logic [1:0] dbg_state, dbg_state4;

  ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_RD_LAT(LAT)) u_dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .bus(bus), .o_dbg_state(dbg_state));
  ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_RD_LAT(LAT4)) u_dut4 (
    .i_sys_clk(clk), .i_sys_rst(rst), .bus(bus4), .o_dbg_state(dbg_state4));

  // RAM models: data shows up on i_ram_rd_data only in the cycle the latency dictates
  logic [DW-1:0] mem [0:7];
  logic [DW-1:0] pipe [0:3];
  logic [DW-1:0] pipe4 [0:3];

  function automatic int midx(input logic [AW-1:0] a);
    return int'({a[31], a[3:2]});
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      mem[0] <= 32'h1111_1111; mem[1] <= 32'h2222_2222;
      mem[2] <= 32'h5555_AAAA; mem[3] <= 32'h0;
      mem[4] <= 32'h0000_0013; mem[5] <= 32'h0000_0093;
      mem[6] <= 32'h0000_0513; mem[7] <= 32'h0;
    end else if (bus.o_ram_wr_en) begin
      for (int b = 0; b < MW; b++)
        if (bus.o_ram_wr_mask[b])
          mem[midx(bus.o_ram_wr_addr)][b*8 +: 8] <= bus.o_ram_wr_data[b*8 +: 8];
    end
    pipe[0]  <= bus.o_ram_rd_en ? mem[midx(bus.o_ram_rd_addr)] : 32'h5A5A_5A5A;
    pipe4[0] <= bus4.o_ram_rd_en ? 32'h1234_5678 : 32'h5A5A_5A5A;
    for (int i = 1; i < 4; i++) begin
      pipe[i]  <= pipe[i-1];
      pipe4[i] <= pipe4[i-1];
    end
  end
  assign bus.i_ram_rd_data  = pipe[LAT-1];
  assign bus4.i_ram_rd_data = pipe4[LAT4-1];

  logic [RSP_W-1:0] exp_rsp_q[$];
  logic [RSP_W-1:0] exp_rsp4_q[$];
  logic [CMD_W-1:0] exp_cmd_q[$];
  logic             grant_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s (cycle %0d)", name, what, cyc);
  endtask

  // Response scoreboard, main DUT
  logic          m_who;
  logic [DW-1:0] m_data;
  logic [31:0]   m_cyc;
  always @(negedge clk) begin
    if (bus.o_ifu_rsp_valid) ifu_rsp_cnt++;
    if (bus.o_lsu_rsp_valid) lsu_rsp_cnt++;
    if (bus.o_ifu_rsp_valid && bus.o_lsu_rsp_valid)
      fail("rsp_both", "two rsp pulses, expected at most one");
    else if (bus.o_ifu_rsp_valid || bus.o_lsu_rsp_valid) begin
      if (exp_rsp_q.size() == 0)
        fail("rsp_unexpected", "rsp pulse, expected none");
      else begin
        {m_who, m_data, m_cyc} = exp_rsp_q.pop_front();
        check("rsp_who", bus.o_lsu_rsp_valid, m_who);
        check("rsp_data", bus.o_lsu_rsp_valid ? bus.o_lsu_rsp_data : bus.o_ifu_rsp_data, m_data);
        check("rsp_cycle", cyc, m_cyc);
      end
    end
  end

  // Response scoreboard, RAM_RD_LAT=4 DUT
  logic          m4_who;
  logic [DW-1:0] m4_data;
  logic [31:0]   m4_cyc;
  always @(negedge clk) begin
    if (bus4.o_ifu_rsp_valid || bus4.o_lsu_rsp_valid) begin
      if (exp_rsp4_q.size() == 0 || (bus4.o_ifu_rsp_valid && bus4.o_lsu_rsp_valid))
        fail("rsp4_unexpected", "rsp pulse, expected none");
      else begin
        {m4_who, m4_data, m4_cyc} = exp_rsp4_q.pop_front();
        check("rsp4_who", bus4.o_lsu_rsp_valid, m4_who);
        check("rsp4_data", bus4.o_lsu_rsp_valid ? bus4.o_lsu_rsp_data : bus4.o_ifu_rsp_data, m4_data);
        check("rsp4_cycle", cyc, m4_cyc);
      end
    end
  end

  // RAM command scoreboard, main DUT
  logic          c_wr;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [MW-1:0] c_mask;
  logic [31:0]   c_cyc;
  always @(negedge clk) begin
    if (bus.o_ram_rd_en || bus.o_ram_wr_en) begin
      if (exp_cmd_q.size() == 0)
        fail("cmd_unexpected", "RAM command, expected none");
      else begin
        {c_wr, c_addr, c_wdata, c_mask, c_cyc} = exp_cmd_q.pop_front();
        check("cmd_fields",
              {bus.o_ram_rd_en, bus.o_ram_wr_en, bus.o_ram_rd_addr, bus.o_ram_wr_addr,
               bus.o_ram_wr_data, bus.o_ram_wr_mask},
              c_wr ? {2'b01, 32'h0, c_addr, c_wdata, c_mask}
                   : {2'b10, c_addr, 32'h0, 32'h0, 4'h0});
        check("cmd_cycle", cyc, c_cyc);
      end
    end else begin
      check("cmd_idle_zero",
            {bus.o_ram_rd_addr, bus.o_ram_wr_addr, bus.o_ram_wr_data, bus.o_ram_wr_mask}, '0);
    end
  end

  task automatic ifu_req(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data, output int acc);
    bus.i_ifu_req_valid = 1'b1;
    bus.i_ifu_req_addr  = addr;
    acc = -1;
    for (int i = 0; i < 64 && acc < 0; i++) begin
      @(negedge clk);
      if (bus.o_ifu_req_ready) acc = cyc;
    end
    if (acc < 0) begin
      fail("ifu_accept_timeout", "no ready within 64 cycles");
      bus.i_ifu_req_valid = 1'b0;
    end else begin
      exp_rsp_q.push_back({1'b0, exp_data, 32'(acc + 2 + LAT)});
      exp_cmd_q.push_back({1'b0, addr, 32'h0, 4'h0, 32'(acc + 1)});
      grant_q.push_back(1'b0);
      @(posedge clk); #1;
      bus.i_ifu_req_valid = 1'b0;
    end
  endtask

  task automatic lsu_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [MW-1:0] mask, input logic [DW-1:0] exp_data, output int acc);
    bus.i_lsu_req_valid = 1'b1;
    bus.i_lsu_req_wr    = wr;
    bus.i_lsu_req_addr  = addr;
    bus.i_lsu_req_wdata = wdata;
    bus.i_lsu_req_mask  = mask;
    acc = -1;
    for (int i = 0; i < 64 && acc < 0; i++) begin
      @(negedge clk);
      if (bus.o_lsu_req_ready) acc = cyc;
    end
    if (acc < 0) begin
      fail("lsu_accept_timeout", "no ready within 64 cycles");
      bus.i_lsu_req_valid = 1'b0;
    end else begin
      exp_rsp_q.push_back({1'b1, exp_data, 32'(acc + (wr ? 2 : 2 + LAT))});
      exp_cmd_q.push_back({wr, addr, wdata, mask, 32'(acc + 1)});
      grant_q.push_back(1'b1);
      @(posedge clk); #1;
      bus.i_lsu_req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_rsp_q.size() != 0 || exp_rsp4_q.size() != 0 ||
                                dbg_state != 2'd0 || dbg_state4 != 2'd0); i++)
      @(negedge clk);
    if (exp_rsp_q.size() != 0 || exp_rsp4_q.size() != 0)
      fail("drain_timeout", "responses still outstanding after 200 cycles");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, t4, rel;
    logic [AW-1:0] l_addr [3];
    logic [DW-1:0] l_data [3];
    logic [AW-1:0] i_addr [3];
    logic [DW-1:0] i_data [3];
    logic          g_exp  [6];
    int            ifu0, lsu0;

    l_addr = '{32'h100, 32'h104, 32'h108};
    l_data = '{32'h1111_BEEF, 32'hCAFE_F00D, 32'h5555_AAAA};
    i_addr = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    i_data = '{32'h0000_0013, 32'h0000_0093, 32'h0000_0513};
    g_exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    ram_load = 1'b1;
    bus.i_ifu_req_valid = 1'b0;  bus.i_ifu_req_addr = '0;
    bus.i_lsu_req_valid = 1'b0;  bus.i_lsu_req_wr = 1'b0;  bus.i_lsu_req_addr = '0;
    bus.i_lsu_req_wdata = '0;    bus.i_lsu_req_mask = '0;
    bus4.i_ifu_req_valid = 1'b0; bus4.i_ifu_req_addr = '0;
    bus4.i_lsu_req_valid = 1'b0; bus4.i_lsu_req_wr = 1'b0; bus4.i_lsu_req_addr = '0;
    bus4.i_lsu_req_wdata = '0;   bus4.i_lsu_req_mask = '0;

    // Reset state, with both requesters asking while reset is held
    repeat (3) @(posedge clk);
    bus.i_ifu_req_valid = 1'b1;
    bus.i_lsu_req_valid = 1'b1;
    @(negedge clk);
    check("rst_state", {dbg_state, dbg_state4}, 4'h0);
    check("rst_ready", {bus.o_ifu_req_ready, bus.o_lsu_req_ready}, 2'b00);
    check("rst_outputs", {bus.o_ifu_rsp_valid, bus.o_lsu_rsp_valid, bus.o_ram_rd_en,
                          bus.o_ram_wr_en, bus.o_ifu_rsp_data, bus.o_lsu_rsp_data}, '0);
    @(posedge clk); #1;
    bus.i_ifu_req_valid = 1'b0;
    bus.i_lsu_req_valid = 1'b0;
    rst = 1'b0;
    ram_load = 1'b0;

    // IFU fetch: rd_en at T+1, rsp at T+3
    ifu_req(32'h8000_0000, 32'h0000_0013, a);
    drain();

    // LSU masked write: wr_en at T+1, ack with data 0 at T+2
    lsu_req(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 32'h0, a);
    drain();

    // IFU raised during the write's ISSUE cycle is accepted at T+3
    lsu_req(1'b1, 32'h104, 32'hCAFE_F00D, 4'b1111, 32'h0, a);
    ifu_req(32'h8000_0004, 32'h0000_0093, b);
    check("ifu_after_write_accept", b, a + 3);
    drain();

    // Both requesters continuously valid: strict alternation from the LSU
    grant_q.delete();
    ifu0 = ifu_rsp_cnt;
    lsu0 = lsu_rsp_cnt;
    fork
      begin
        int x;
        for (int k = 0; k < 3; k++) lsu_req(1'b0, l_addr[k], 32'h0, 4'h0, l_data[k], x);
      end
      begin
        int y;
        for (int k = 0; k < 3; k++) ifu_req(i_addr[k], i_data[k], y);
      end
    join
    drain();
    check("rr_grant_count", grant_q.size(), 6);
    for (int k = 0; k < 6 && k < grant_q.size(); k++)
      check($sformatf("rr_grant_%0d", k), grant_q[k], g_exp[k]);
    check("rr_ifu_pulses", ifu_rsp_cnt - ifu0, 3);
    check("rr_lsu_pulses", lsu_rsp_cnt - lsu0, 3);

    // Reset during WAIT of an IFU read aborts it; LSU accepted right after release
    bus.i_ifu_req_valid = 1'b1;
    bus.i_ifu_req_addr  = 32'h8000_0008;
    a = -1;
    for (int i = 0; i < 64 && a < 0; i++) begin
      @(negedge clk);
      if (bus.o_ifu_req_ready) a = cyc;
    end
    if (a < 0) fail("abort_accept_timeout", "no ready within 64 cycles");
    exp_cmd_q.push_back({1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'(a + 1)});
    @(posedge clk); #1;
    bus.i_ifu_req_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_in_wait", dbg_state, 2'd2);
    rst = 1'b1;
    rel = -1;
    fork
      lsu_req(1'b0, 32'h108, 32'h0, 4'h0, 32'h5555_AAAA, b);
      begin
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs", {bus.o_ifu_req_ready, bus.o_lsu_req_ready, bus.o_ifu_rsp_valid,
                                bus.o_lsu_rsp_valid, bus.o_ram_rd_en, bus.o_ram_wr_en,
                                bus.o_ifu_rsp_data, bus.o_lsu_rsp_data}, '0);
        check("abort_state", dbg_state, 2'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rel = cyc;
      end
    join
    check("post_reset_accept", b, rel);
    drain();

    // RAM_RD_LAT=4: LSU read, data sampled at T+5, rsp at T+6, busy T+1..T+6
    bus4.i_lsu_req_valid = 1'b1;
    bus4.i_lsu_req_addr  = 32'h0000_1234;
    t4 = -1;
    for (int i = 0; i < 64 && t4 < 0; i++) begin
      @(negedge clk);
      if (bus4.o_lsu_req_ready) t4 = cyc;
    end
    if (t4 < 0) fail("lat4_accept_timeout", "no ready within 64 cycles");
    exp_rsp4_q.push_back({1'b1, 32'h1234_5678, 32'(t4 + 6)});
    @(posedge clk); #1;
    bus4.i_lsu_req_addr  = 32'h0000_2000;
    bus4.i_ifu_req_valid = 1'b1;
    bus4.i_ifu_req_addr  = 32'h0000_3000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("lat4_ready_low_T+%0d", k), {bus4.o_ifu_req_ready, bus4.o_lsu_req_ready}, 2'b00);
      check($sformatf("lat4_rd_cmd_T+%0d", k), {bus4.o_ram_rd_en, bus4.o_ram_rd_addr},
            (k == 1) ? {1'b1, 32'h0000_1234} : 33'h0);
    end
    @(negedge clk);
    check("lat4_ifu_wins_T+7", {bus4.o_ifu_req_ready, bus4.o_lsu_req_ready}, 2'b10);
    exp_rsp4_q.push_back({1'b0, 32'h1234_5678, 32'(t4 + 13)});
    @(posedge clk); #1;
    bus4.i_ifu_req_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("lat4_lsu_next_T+14", {bus4.o_ifu_req_ready, bus4.o_lsu_req_ready}, 2'b01);
    exp_rsp4_q.push_back({1'b1, 32'h1234_5678, 32'(t4 + 20)});
    @(posedge clk); #1;
    bus4.i_lsu_req_valid = 1'b0;
    drain();

    check("end_rsp_q_empty", exp_rsp_q.size() + exp_rsp4_q.size(), 0);
    check("end_cmd_q_empty", exp_cmd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arb.md
# ram_arb

Single-port RAM arbiter and sequencer for the multi-cycle core. It shares the one data RAM between two requesters: the instruction fetch path (IFU, read-only) and the load/store path (LSU, read or masked write). Each request is accepted through a valid/ready handshake and issued to the RAM with registered command outputs. The read response returns after a parameterised RAM latency. It sits between `ifu`/`lsu` and `ram` inside `cpu`, and drives the instruction word the IDU consumes.

## Interface
Parameters:
- DATA_WIDTH, 32, RAM data width; mask width is DATA_WIDTH/8.
- ADDR_WIDTH, 32, RAM address width.
- RAM_RD_LAT, 1, cycles from `o_ram_rd_en` high to valid `i_ram_rd_data`; legal range 1..4.

Ports:
- i_sys_clk  in  1  clock; all logic on rising edge.
- i_sys_rst  in  1  reset; synchronous, active-high.
- i_ifu_req_valid  in  1  IFU fetch request.
- o_ifu_req_ready  out  1  IFU request accepted this cycle.
- i_ifu_req_addr  in  ADDR_WIDTH  fetch address.
- o_ifu_rsp_valid  out  1  one-cycle pulse; fetch data valid.
- o_ifu_rsp_data  out  DATA_WIDTH  fetched instruction word.
- i_lsu_req_valid  in  1  LSU request.
- o_lsu_req_ready  out  1  LSU request accepted this cycle.
- i_lsu_req_wr  in  1  1 = write, 0 = read.
- i_lsu_req_addr  in  ADDR_WIDTH  access address.
- i_lsu_req_wdata  in  DATA_WIDTH  write data.
- i_lsu_req_mask  in  DATA_WIDTH/8  byte write mask.
- o_lsu_rsp_valid  out  1  one-cycle pulse; read data valid or write done.
- o_lsu_rsp_data  out  DATA_WIDTH  read data; 0 for write acks.
- o_ram_rd_en / o_ram_rd_addr  out  1 / ADDR_WIDTH  RAM read command.
- i_ram_rd_data  in  DATA_WIDTH  RAM read data.
- o_ram_wr_en / o_ram_wr_addr / o_ram_wr_data / o_ram_wr_mask  out  1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  RAM write command.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. One transaction is in flight at a time.
- IDLE: the block selects a winner among the valid requesters. It raises only the winner's `req_ready`, combinationally from state, valids and `r_last`.
- Handshake: a request is accepted when `valid && ready` at a clock edge. On accept the block latches the requester, wr, addr, wdata and mask, sets `r_last` to the winner, and moves to ISSUE.
- Requesters hold valid and payload until ready. Dropping valid before accept is legal and has no effect.
- Round-robin arbitration:
  - Both valid: the requester not equal to `r_last` wins.
  - One valid: that requester wins.
  - Reset sets `r_last` = IFU, so the LSU wins the first tie.
- ISSUE (1 cycle):
  - Read: `o_ram_rd_en` = 1 with the latched address; then go to WAIT.
  - Write: `o_ram_wr_en` = 1 with the latched addr, data and mask; then go to RESP.
- WAIT: lasts RAM_RD_LAT cycles, counted by a down-counter. `i_ram_rd_data` is captured on the final WAIT cycle; then go to RESP.
- RESP (1 cycle):
  - The owner's `rsp_valid` = 1. `rsp_data` holds the captured word, or 0 for a write.
  - The other requester's `rsp_valid` stays 0.
  - Next state is IDLE.
- `o_ifu_req_ready` and `o_lsu_req_ready` are 0 in every state except IDLE.
- IFU requests are always reads. The write-command outputs are never driven for an IFU request.
- Outside ISSUE, all RAM command outputs are 0, including addr, data and mask.

## Timing
- Reset: state = IDLE, `r_last` = IFU, WAIT counter = 0, and every registered output = 0.
- Reset asserted mid-transaction aborts it: no `rsp_valid` pulse, and RAM commands are 0 from the cycle after the reset edge.
- Read latency (accept at cycle T):
  - ISSUE at T+1.
  - Data sampled at T+1+RAM_RD_LAT.
  - `rsp_valid` at T+2+RAM_RD_LAT.
  - Next accept possible at T+3+RAM_RD_LAT.
- Write latency (accept at cycle T): `o_ram_wr_en` at T+1, `rsp_valid` at T+2, next accept possible at T+3.
- Back-to-back with both requesters always valid: grants strictly alternate, starting with the LSU.
- A request arriving while busy waits. It is not dropped and is not starved beyond one transaction of the other requester.
- `rsp_valid` is exactly one cycle wide, and there is exactly one pulse per accepted request.

## Test plan
- Reset, then IFU read of addr 0x8000_0000 with RAM returning 0x0000_0013 at RAM_RD_LAT=1 -> `o_ram_rd_en` at T+1, `o_ifu_rsp_valid` with 0x0000_0013 at T+3.
- LSU write addr 0x100, data 0xDEAD_BEEF, mask 4'b0011 -> `o_ram_wr_en` at T+1 with exact addr/data/mask, `o_lsu_rsp_valid` with data 0 at T+2, `o_ram_rd_en` never high.
- Both requesters held valid for 6 transactions -> grant order LSU, IFU, LSU, IFU, LSU, IFU; each requester gets exactly 3 rsp pulses.
- RAM_RD_LAT=4, LSU read returning 0x1234_5678 -> sampled at T+5, `o_lsu_rsp_valid` at T+6; `o_lsu_req_ready`/`o_ifu_req_ready` low T+1..T+6.
- `i_sys_rst` asserted during WAIT of an IFU read -> no `o_ifu_rsp_valid` pulse, all outputs 0, next LSU request accepted on the first cycle after reset deasserts.
- IFU valid raised during an LSU write's ISSUE cycle -> IFU accepted in the first IDLE cycle, T+3 after the LSU accept.
